// File: rtl/stage_pkg.sv
// stage_pkg: shared FSM states, branch-type codes and predictor counter update for stage_ctrl.
package stage_pkg;
  typedef enum logic [1:0] {RUN, LD_STALL, MEM_WAIT, REDIRECT} state_t;
  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_COND = 2'b01;
  localparam logic [1:0] BR_JUMP = 2'b10;
  // An entry without valid history starts weakly biased toward the observed outcome.
  function automatic logic [1:0] sat2_update(input logic valid, input logic [1:0] ctr, input logic taken);
    return !valid ? (taken ? 2'b10 : 2'b01) :
           taken  ? ((ctr == 2'b11) ? ctr : ctr + 2'd1) :
                    ((ctr == 2'b00) ? ctr : ctr - 2'd1);
  endfunction
endpackage

// File: rtl/stage_ctrl_if.sv
// stage_ctrl_if: hazard inputs from the IF/ID/AD latches and the controls/counters driven back to them.
interface stage_ctrl_if #(parameter int PERF_W = 16);
  logic [4:0] rs1_id, rs2_id, rd_ad;
  logic rs1_used_id, rs2_used_id, rd_memory_ad;
  logic [1:0] flag_branch_ad, prev_counter_ad;
  logic branch_taken_ad, prev_valid_ad, prev_branch_prediction_ad;
  logic [31:0] prev_pc_ad, pc_target_ad;
  logic dmem_ready;
  logic ena_if, ena_id, ena_ad, x_id, x_ad;
  logic pc_redirect;
  logic [31:0] pc_redirect_addr;
  logic bp_update_en;
  logic [1:0] bp_counter_new;
  logic [PERF_W-1:0] stall_count, flush_count;
  modport ctrl (
    input rs1_id, rs2_id, rs1_used_id, rs2_used_id, rd_ad, rd_memory_ad, flag_branch_ad,
          branch_taken_ad, prev_valid_ad, prev_branch_prediction_ad, prev_counter_ad,
          prev_pc_ad, pc_target_ad, dmem_ready,
    output ena_if, ena_id, ena_ad, x_id, x_ad, pc_redirect, pc_redirect_addr,
           bp_update_en, bp_counter_new, stall_count, flush_count
  );
  modport pipe (
    output rs1_id, rs2_id, rs1_used_id, rs2_used_id, rd_ad, rd_memory_ad, flag_branch_ad,
           branch_taken_ad, prev_valid_ad, prev_branch_prediction_ad, prev_counter_ad,
           prev_pc_ad, pc_target_ad, dmem_ready,
    input ena_if, ena_id, ena_ad, x_id, x_ad, pc_redirect, pc_redirect_addr,
          bp_update_en, bp_counter_new, stall_count, flush_count
  );
endinterface

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping.
module sat_counter #(parameter int W = 16) (
  input  logic         stg_clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge stg_clk or negedge reset)
    if (!reset) count <= '0;
    else if (inc && !(&count)) count <= count + W'(1);
endmodule

// File: rtl/stage_ctrl.sv
// stage_ctrl: sequences the IF/ID/AD latches around load-use, memory-wait and mispredict events,
// issuing PC redirects and predictor counter updates.
module stage_ctrl
  import stage_pkg::*;
#(parameter int PERF_W = 16) (
  input logic       stg_clk,
  input logic       reset,
  stage_ctrl_if.ctrl s
);
  state_t state, state_nx;
  logic cond, jump, is_br, pred, mp, lu, mw;
  logic ev_mw, ev_mp, ev_lu;
  logic ena_if, ena_id, ena_ad, x_id, x_ad, redir;
  always_comb begin
    cond  = s.flag_branch_ad == BR_COND;
    jump  = s.flag_branch_ad == BR_JUMP;
    is_br = cond | jump;
    pred  = s.prev_valid_ad & s.prev_branch_prediction_ad;
    mp    = (cond & (s.branch_taken_ad != pred)) | (jump & !pred);
    lu    = s.rd_memory_ad & (s.rd_ad != 5'd0) &
            ((s.rs1_used_id & (s.rs1_id == s.rd_ad)) | (s.rs2_used_id & (s.rs2_id == s.rd_ad)));
    mw    = s.rd_memory_ad & !s.dmem_ready;
  end
  // The cycle after a load stall only re-checks memory; the cycle after a redirect checks nothing.
  always_comb begin
    ena_if   = 1'b1;
    ena_id   = 1'b1;
    ena_ad   = 1'b1;
    x_id     = 1'b0;
    x_ad     = 1'b0;
    redir    = 1'b0;
    state_nx = RUN;
    ev_mw    = (state == MEM_WAIT) ? !s.dmem_ready : (state != REDIRECT) & mw;
    ev_mp    = ((state == RUN) | (state == MEM_WAIT)) & mp;
    ev_lu    = ((state == RUN) | (state == MEM_WAIT)) & lu;
    if (ev_mw) begin
      ena_if   = 1'b0;
      ena_id   = 1'b0;
      ena_ad   = 1'b0;
      state_nx = MEM_WAIT;
    end else if (ev_mp) begin
      x_id     = 1'b1;
      x_ad     = 1'b1;
      redir    = 1'b1;
      state_nx = REDIRECT;
    end else if (ev_lu) begin
      ena_if   = 1'b0;
      ena_id   = 1'b0;
      x_ad     = 1'b1;
      state_nx = LD_STALL;
    end else begin
      x_id = state == REDIRECT;
    end
  end
  always_ff @(posedge stg_clk or negedge reset)
    if (!reset) state <= RUN;
    else state <= state_nx;
  assign s.ena_if           = ena_if | !reset;
  assign s.ena_id           = ena_id | !reset;
  assign s.ena_ad           = ena_ad | !reset;
  assign s.x_id             = x_id & reset;
  assign s.x_ad             = x_ad & reset;
  assign s.pc_redirect      = redir & reset;
  assign s.pc_redirect_addr = s.pc_redirect ? (s.branch_taken_ad ? s.pc_target_ad : s.prev_pc_ad + 32'd4) : 32'd0;
  assign s.bp_update_en     = reset & is_br & ena_ad;
  assign s.bp_counter_new   = s.bp_update_en ?
                              sat2_update(s.prev_valid_ad, s.prev_counter_ad, s.branch_taken_ad | jump) : 2'b00;
  sat_counter #(.W(PERF_W)) u_stall (.stg_clk(stg_clk), .reset(reset), .inc(!s.ena_if), .count(s.stall_count));
  sat_counter #(.W(PERF_W)) u_flush (.stg_clk(stg_clk), .reset(reset), .inc(s.pc_redirect), .count(s.flush_count));
endmodule

// File: tb/tb_stage_ctrl.sv
// tb_stage_ctrl: directed scenarios for stage_ctrl checked every cycle against an event-level model,
// with literal expectations at the key points of each scenario.
module tb_stage_ctrl;
  localparam int PERF_W = 4;
  localparam int SAT = (1 << PERF_W) - 1;
  logic stg_clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  stage_ctrl_if #(.PERF_W(PERF_W)) bus();
  stage_ctrl #(.PERF_W(PERF_W)) dut (.stg_clk(stg_clk), .reset(reset), .s(bus));
  always #5 stg_clk = ~stg_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // hist: what the previous cycle did -- 0 advanced, 1 load stall, 2 waiting on memory, 3 redirected
  int hist = 0;
  int m_stall = 0;
  int m_flush = 0;
  always @(negedge stg_clk) begin : model
    logic e_if, e_id, e_ad, e_xid, e_xad, e_red, e_bp;
    logic [31:0] e_addr;
    bit cond, jmp, br, pred, act, mp, lu, mw, blk;
    int c, nh;
    cond = bus.flag_branch_ad == 2'b01;
    jmp  = bus.flag_branch_ad == 2'b10;
    br   = cond || jmp;
    pred = bus.prev_valid_ad && bus.prev_branch_prediction_ad;
    act  = jmp || (cond && bus.branch_taken_ad);
    mp   = br && (act != pred);
    lu   = bus.rd_memory_ad && bus.rd_ad != 0 &&
           ((bus.rs1_used_id && bus.rs1_id == bus.rd_ad) || (bus.rs2_used_id && bus.rs2_id == bus.rd_ad));
    mw   = bus.rd_memory_ad && !bus.dmem_ready;
    {e_if, e_id, e_ad} = 3'b111;
    {e_xid, e_xad, e_red} = 3'b000;
    nh = 0;
    if (reset) begin
      if (hist == 3) e_xid = 1'b1;
      else begin
        blk = (hist == 2) ? !bus.dmem_ready : mw;
        if (blk) begin
          {e_if, e_id, e_ad} = 3'b000;
          nh = 2;
        end else if (hist != 1 && mp) begin
          {e_xid, e_xad, e_red} = 3'b111;
          nh = 3;
        end else if (hist != 1 && lu) begin
          {e_if, e_id, e_xad} = 3'b001;
          nh = 1;
        end
      end
    end
    e_bp = reset && br && e_ad;
    c = 0;
    if (e_bp) begin
      c = bus.prev_counter_ad;
      if (!bus.prev_valid_ad) c = act ? 2 : 1;
      else if (act) c = (c == 3) ? 3 : c + 1;
      else c = (c == 0) ? 0 : c - 1;
    end
    e_addr = e_red ? (bus.branch_taken_ad ? bus.pc_target_ad : bus.prev_pc_ad + 32'd4) : 32'd0;
    if (!reset) begin
      m_stall = 0;
      m_flush = 0;
    end
    chk("ena_if", bus.ena_if, e_if);
    chk("ena_id", bus.ena_id, e_id);
    chk("ena_ad", bus.ena_ad, e_ad);
    chk("x_id", bus.x_id, e_xid);
    chk("x_ad", bus.x_ad, e_xad);
    chk("pc_redirect", bus.pc_redirect, e_red);
    chk("pc_redirect_addr", bus.pc_redirect_addr, e_addr);
    chk("bp_update_en", bus.bp_update_en, e_bp);
    chk("bp_counter_new", bus.bp_counter_new, c);
    chk("stall_count", bus.stall_count, m_stall);
    chk("flush_count", bus.flush_count, m_flush);
    if (reset) begin
      hist = nh;
      if (!e_if && m_stall < SAT) m_stall++;
      if (e_red && m_flush < SAT) m_flush++;
    end else hist = 0;
  end

  task automatic tick();
    @(posedge stg_clk);
    #1;
  endtask

  task automatic idle();
    bus.rs1_id = 5'd0; bus.rs2_id = 5'd0; bus.rs1_used_id = 1'b0; bus.rs2_used_id = 1'b0;
    bus.rd_ad = 5'd0; bus.rd_memory_ad = 1'b0; bus.flag_branch_ad = 2'b00; bus.branch_taken_ad = 1'b0;
    bus.prev_valid_ad = 1'b0; bus.prev_branch_prediction_ad = 1'b0; bus.prev_counter_ad = 2'b00;
    bus.prev_pc_ad = 32'h40; bus.pc_target_ad = 32'h0; bus.dmem_ready = 1'b1;
  endtask

  task automatic branch(input logic [1:0] fb, input logic tk, input logic pv, input logic pbp,
                        input logic [1:0] ctr, input logic [31:0] pc, input logic [31:0] tgt);
    bus.flag_branch_ad = fb; bus.branch_taken_ad = tk; bus.prev_valid_ad = pv;
    bus.prev_branch_prediction_ad = pbp; bus.prev_counter_ad = ctr; bus.prev_pc_ad = pc; bus.pc_target_ad = tgt;
  endtask

  initial begin
    idle();
    #1 chk("reset ena_if", bus.ena_if, 1);
    chk("reset bp_counter_new", bus.bp_counter_new, 0);
    tick();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("idle stall_count", bus.stall_count, 0);
    chk("idle ena_id", bus.ena_id, 1);
    // load-use on rs1
    bus.rd_memory_ad = 1'b1; bus.rd_ad = 5'd5; bus.rs1_id = 5'd5; bus.rs1_used_id = 1'b1;
    #1 chk("lu ena_if", bus.ena_if, 0);
    chk("lu x_ad", bus.x_ad, 1);
    tick();
    idle();
    #1 chk("lu_after ena_if", bus.ena_if, 1);
    tick();
    chk("lu stall_count", bus.stall_count, 1);
    // conditional taken, predicted not-taken
    branch(2'b01, 1, 1, 0, 2'b01, 32'h80, 32'h100);
    #1 chk("mp addr", bus.pc_redirect_addr, 32'h100);
    chk("mp x_id", bus.x_id, 1);
    chk("mp ctr", bus.bp_counter_new, 2'b10);
    tick();
    idle();
    #1 chk("redirect x_id", bus.x_id, 1);
    chk("redirect pc_redirect", bus.pc_redirect, 0);
    tick();
    chk("mp flush_count", bus.flush_count, 1);
    // not-taken predicted taken, PC wraps
    branch(2'b01, 0, 1, 1, 2'b11, 32'hFFFF_FFFC, 32'h500);
    #1 chk("wrap addr", bus.pc_redirect_addr, 32'h0);
    chk("wrap ctr", bus.bp_counter_new, 2'b10);
    tick(); idle(); tick();
    // unpredicted jump plus load-use: redirect wins
    branch(2'b10, 1, 0, 0, 2'b00, 32'h20, 32'h300);
    bus.rd_memory_ad = 1'b1; bus.rd_ad = 5'd3; bus.rs2_id = 5'd3; bus.rs2_used_id = 1'b1;
    #1 chk("mplu ena_if", bus.ena_if, 1);
    chk("mplu addr", bus.pc_redirect_addr, 32'h300);
    tick(); idle(); tick();
    // correctly predicted jump, saturating counter
    branch(2'b10, 1, 1, 1, 2'b11, 32'h20, 32'h300);
    #1 chk("jmp ok redirect", bus.pc_redirect, 0);
    chk("jmp ok ctr", bus.bp_counter_new, 2'b11);
    tick();
    branch(2'b11, 1, 0, 0, 2'b01, 32'h20, 32'h300);
    #1 chk("reserved bp_update_en", bus.bp_update_en, 0);
    tick(); idle();
    // memory wait overlapping a mispredict
    branch(2'b01, 1, 0, 0, 2'b00, 32'h60, 32'h200);
    bus.rd_memory_ad = 1'b1; bus.dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("mw ena_ad", bus.ena_ad, 0);
      tick();
    end
    bus.dmem_ready = 1'b1;
    #1 chk("mw ready redirect", bus.pc_redirect, 1);
    chk("mw ready addr", bus.pc_redirect_addr, 32'h200);
    tick(); idle(); tick();
    chk("mw stall_count", bus.stall_count, 4);
    chk("mw flush_count", bus.flush_count, 4);
    // saturate both counters
    bus.rd_memory_ad = 1'b1; bus.dmem_ready = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    idle(); tick();
    chk("sat stall_count", bus.stall_count, SAT);
    for (int i = 0; i < 13; i++) begin
      branch(2'b10, 1, 0, 0, 2'b00, 32'h10, 32'h400);
      tick(); idle(); tick();
    end
    chk("sat flush_count", bus.flush_count, SAT);
    // reset while waiting on memory
    bus.rd_memory_ad = 1'b1; bus.dmem_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    #1 chk("rst ena_if", bus.ena_if, 1);
    chk("rst stall_count", bus.stall_count, 0);
    chk("rst flush_count", bus.flush_count, 0);
    tick();
    bus.rd_memory_ad = 1'b0;
    reset = 1'b1;
    #1 chk("post-rst ena_if", bus.ena_if, 1);
    tick(); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/stage_ctrl.md
# stage_ctrl

Pipeline sequencing controller for the IF/ID/AD latch chain. Each cycle it drives every latch's `stg_ena` and `stg_x` (bubble) inputs. It detects load-use hazards, data-memory wait and branch misprediction at the AD stage. On a misprediction it issues the PC redirect and produces the 2-bit predictor counter update. It sits beside the pipeline latches and is the only source of their enable and flush controls.

## Interface
Parameters:
- `PERF_W`, default 16: width of the saturating performance counters.

Ports:
- `stg_clk` in 1: pipeline clock. All state is updated on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `rs1_id`, `rs2_id` in 5 each: source registers of the instruction in ID.
- `rs1_used_id`, `rs2_used_id` in 1 each: the corresponding source register is read.
- `rd_ad` in 5: destination register of the instruction in AD.
- `rd_memory_ad` in 1: the instruction in AD is a load.
- `flag_branch_ad` in 2: branch type in AD. 00 = none, 01 = conditional, 10 = jump, 11 = reserved (treated as none).
- `branch_taken_ad` in 1: resolved outcome of the branch in AD.
- `prev_valid_ad`, `prev_branch_prediction_ad` in 1 each: prediction state carried with the AD instruction.
- `prev_counter_ad` in 2: predictor counter carried with the AD instruction.
- `prev_pc_ad`, `pc_target_ad` in 32 each: PC and resolved target of the AD instruction.
- `dmem_ready` in 1: data memory has completed the access.
- `ena_if`, `ena_id`, `ena_ad` out 1 each: latch enables.
- `x_id`, `x_ad` out 1 each: bubble insert for the ID and AD latches.
- `pc_redirect` out 1: load the PC from `pc_redirect_addr`.
- `pc_redirect_addr` out 32: redirect target.
- `bp_update_en` out 1: write the predictor entry.
- `bp_counter_new` out 2: new counter value for that entry.
- `stall_count`, `flush_count` out `PERF_W` each: saturating event counters.

## Operation
- FSM states: RUN, LD_STALL, MEM_WAIT, REDIRECT. Reset state is RUN.
- Mispredict condition (`mp`):
  - conditional branch with `branch_taken_ad` ≠ (`prev_valid_ad` & `prev_branch_prediction_ad`), or
  - jump with (`!prev_valid_ad` | `!prev_branch_prediction_ad`).
- Load-use hazard (`lu`): `rd_memory_ad` & `rd_ad`≠0 & ((`rs1_used_id` & `rs1_id`==`rd_ad`) | (`rs2_used_id` & `rs2_id`==`rd_ad`)).
- Memory wait (`mw`): `rd_memory_ad` & !`dmem_ready`.
- Evaluation priority in RUN is `mw` > `mp` > `lu`:
  - `mw`: all enables 0, no x. Go to MEM_WAIT.
  - `mp`:
    - all enables 1, `x_id`=`x_ad`=1, `pc_redirect`=1.
    - `pc_redirect_addr` = `branch_taken_ad` ? `pc_target_ad` : `prev_pc_ad`+4 (modulo 2^32).
    - Go to REDIRECT.
  - `lu`: `ena_if`=`ena_id`=0, `ena_ad`=1, `x_ad`=1. Go to LD_STALL.
  - None of the above: all enables 1, x 0.
- LD_STALL: lasts exactly one cycle. Outputs as with no event, then return to RUN. `lu` is not re-evaluated in this cycle; `mw` is, and takes precedence.
- MEM_WAIT: all enables 0 until `dmem_ready`=1. In that cycle, behave as RUN with `mw` forced to 0.
- REDIRECT: `x_id`=1 (the fetch slot after the redirect is discarded), all enables 1. `lu` and `mp` are ignored. Return to RUN.
- Predictor update: `bp_update_en`=1 whenever `flag_branch_ad`∈{01,10} and the pipeline advances (`ena_ad`=1), in any state.
  - Counter with `prev_valid_ad`=0: `bp_counter_new` = taken ? 10 : 01.
  - Otherwise: saturating increment if taken, saturating decrement if not taken (bounds 00 and 11).
  - Jumps always count as taken.
- Performance counters:
  - `stall_count` increments for each cycle in which `ena_if`=0.
  - `flush_count` increments for each `pc_redirect` pulse.
  - Both saturate at all-ones.

## Timing
- All control outputs are combinational from state and inputs (Mealy) and take effect at the next `stg_clk` edge. Zero-cycle decision latency.
- Misprediction penalty is 2 cycles: the cycle flushing ID/AD plus the REDIRECT cycle.
- Load-use penalty is 1 cycle.
- Reset asserted (`reset`=0), at any time including mid-stall:
  - state returns to RUN and counters clear to 0 immediately.
  - outputs: enables 1, x 0, `pc_redirect` 0, `pc_redirect_addr` 0, `bp_update_en` 0, `bp_counter_new` 0.
- `mp` and `lu` in the same cycle: `mp` wins. The stall is discarded because the ID instruction is flushed.
- `mw` and `mp` in the same cycle: MEM_WAIT is entered first. `mp` is evaluated again in the cycle `dmem_ready` rises.

## Structure
- The shared package `stage_pkg` holds:
  - the FSM state enum.
  - branch-type constants BR_NONE, BR_COND, BR_JUMP.
  - the `sat2_update` counter function.
- One sub-module, `sat_counter` (parameterised width, increment, synchronous saturation), instantiated twice for the performance counters.

## Test plan
- No branch, no load for 10 cycles → all enables 1, x 0, `stall_count`=0.
- Load in AD with `rd_ad`=5, `rs1_id`=5, `rs1_used_id`=1 → one cycle with `ena_if`=`ena_id`=0, `x_ad`=1, then RUN; `stall_count`=1.
- Conditional branch taken, predicted not-taken, `pc_target_ad`=0x100 → `pc_redirect`=1 with addr 0x100, `x_id`=`x_ad`=1; next cycle `x_id`=1; `flush_count`=1; `bp_counter_new`=10 from counter 01.
- Not-taken branch predicted taken, `prev_pc_ad`=0xFFFFFFFC → redirect addr 0x00000000 (wrap).
- Load with `dmem_ready`=0 for 3 cycles while `mp` is also true → enables 0 for 3 cycles, then the redirect fires in the ready cycle; `stall_count`=3 (plus 1 only if the redirect cycle stalls, which it does not).
- `reset` pulsed low while in MEM_WAIT → immediate RUN, all outputs at reset values, counters 0.
